// File: rtl/vga_scan_gen.sv
// vga_scan_gen: 640x480@60 raster scan generator with pixel enable, syncs, blanking and line/frame strobes; optional frame_cnt under VGA_FRAME_CNT_EN
module vga_scan_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    output logic       pix_en,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] VCLK_HI = DW'((CLK_DIV + 1) / 2);
    localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [DW-1:0] r_div;
    logic          r_pix_en, r_vclk, r_hs, r_vs, r_blank_n, r_ls, r_fs;
    logic [9:0]    r_hc, r_vc;
    logic          w_hwrap, w_fwrap;
    logic [9:0]    w_hc_nx, w_vc_nx;

    // next raster position for the coming pixel
    always_comb begin
        w_hwrap = r_hc == H_LAST;
        w_hc_nx = w_hwrap ? 10'd0 : r_hc + 10'd1;
        w_vc_nx = w_hwrap ? ((r_vc == V_LAST) ? 10'd0 : r_vc + 10'd1) : r_vc;
        w_fwrap = (w_hc_nx == 10'd0) && (w_vc_nx == 10'd0);
    end

    // clock divider: pixel enable follows the terminal count, VGA_CLK high in the first half of a pixel
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_div    <= '0;
            r_pix_en <= 1'b0;
            r_vclk   <= 1'b0;
        end else begin
            r_div    <= (r_div == DIV_MAX) ? '0 : r_div + 1'b1;
            r_pix_en <= r_div == DIV_MAX;
            r_vclk   <= r_div < VCLK_HI;
        end
    end

    // raster counters and the outputs derived from the position they move to
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_hc      <= 10'd0;
            r_vc      <= 10'd0;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b1;
            r_ls      <= 1'b0;
            r_fs      <= 1'b0;
        end else if (r_pix_en) begin
            r_hc      <= w_hc_nx;
            r_vc      <= w_vc_nx;
            r_hs      <= !((w_hc_nx >= HS_BEG) && (w_hc_nx < HS_END));
            r_vs      <= !((w_vc_nx >= VS_BEG) && (w_vc_nx < VS_END));
            r_blank_n <= (w_hc_nx < H_VIS) && (w_vc_nx < V_VIS);
            r_ls      <= w_hc_nx == 10'd0;
            r_fs      <= w_fwrap;
        end else begin
            r_ls      <= 1'b0;
            r_fs      <= 1'b0;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // frame counter for animation timing, steps with the frame_start strobe
    always_ff @(posedge Clk) begin
        if (!Reset_n)
            r_frame_cnt <= 16'd0;
        else if (r_pix_en && w_fwrap)
            r_frame_cnt <= r_frame_cnt + 16'd1;
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign pix_en      = r_pix_en;
    assign VGA_CLK     = r_vclk;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_SYNC_N  = 1'b0;
    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign line_start  = r_ls;
    assign frame_start = r_fs;
endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: directed bench for vga_scan_gen (default, CLK_DIV=1 and a reduced-size raster for frame-level behaviour)
module tb_vga_scan_gen;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    logic m_pe, m_vclk, m_hs, m_vs, m_bn, m_sn, m_ls, m_fs;
    logic a_pe, a_vclk, a_hs, a_vs, a_bn, a_sn, a_ls, a_fs;
    logic s_pe, s_vclk, s_hs, s_vs, s_bn, s_sn, s_ls, s_fs;
    logic [9:0] m_x, m_y, a_x, a_y, s_x, s_y;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] m_fc, a_fc, s_fc;
`endif

    vga_scan_gen u_m (
        .Clk(Clk), .Reset_n(Reset_n), .pix_en(m_pe), .VGA_CLK(m_vclk), .VGA_HS(m_hs), .VGA_VS(m_vs),
        .VGA_BLANK_N(m_bn), .VGA_SYNC_N(m_sn), .DrawX(m_x), .DrawY(m_y), .line_start(m_ls), .frame_start(m_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(m_fc)
`endif
    );

    vga_scan_gen #(.CLK_DIV(1)) u_a (
        .Clk(Clk), .Reset_n(Reset_n), .pix_en(a_pe), .VGA_CLK(a_vclk), .VGA_HS(a_hs), .VGA_VS(a_vs),
        .VGA_BLANK_N(a_bn), .VGA_SYNC_N(a_sn), .DrawX(a_x), .DrawY(a_y), .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(a_fc)
`endif
    );

    // 16 x 12 raster, 2 Clks per pixel: one frame is 384 Clks, VS lines 8..9, visible 8 x 6
    vga_scan_gen #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .CLK_DIV(2)) u_s (
        .Clk(Clk), .Reset_n(Reset_n), .pix_en(s_pe), .VGA_CLK(s_vclk), .VGA_HS(s_hs), .VGA_VS(s_vs),
        .VGA_BLANK_N(s_bn), .VGA_SYNC_N(s_sn), .DrawX(s_x), .DrawY(s_y), .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(s_fc)
`endif
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    int m_pe_hi = 0, m_pe_dbl = 0, m_xmax = 0, m_ls_n = 0, m_ls_k = -1, m_ls_x = -1, m_fs_n = 0;
    int m_hs_n = 0, m_hs_k0 = -1, m_hs_x0 = -1, m_bn_x0 = -1;
    int a_pe_lo = 0, a_ls_k1 = -1, a_ls_k2 = -1, a_hs_n = 0;
    int s_fs_n = 0, s_fs_k = -1, s_fs_gap = 0, s_fs_last = 0, s_vs_n = 0, s_vs_y0 = -1, s_bn_bad = 0, s_fc3 = -1;
    int wait_n;
    logic prev_pe;

    initial begin
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        check("rst_m", {m_pe, m_vclk, m_hs, m_vs, m_bn, m_sn, m_ls, m_fs, m_x, m_y}, {8'b0011_1000, 20'd0});
        check("rst_a", {a_pe, a_vclk, a_hs, a_vs, a_bn, a_sn, a_ls, a_fs, a_x, a_y}, {8'b0011_1000, 20'd0});
        check("rst_s", {s_pe, s_vclk, s_hs, s_vs, s_bn, s_sn, s_ls, s_fs, s_x, s_y}, {8'b0011_1000, 20'd0});
`ifdef VGA_FRAME_CNT_EN
        check("rst_fc", {m_fc, s_fc}, 32'd0);
        check("rst_fc_a", a_fc, 0);
`endif
        Reset_n = 1'b1;
        tick();
        check("k0_pe", m_pe, 0);
        check("k0_vclk", m_vclk, 1);
        check("k0_a_pe", a_pe, 1);
        check("k0_ls", {m_ls, a_ls, s_ls, m_fs, a_fs, s_fs}, 0);
        tick();
        check("k1_pe", m_pe, 1);
        check("k1_vclk", m_vclk, 0);
        check("k1_x", m_x, 0);
        check("k1_a_x", a_x, 1);
        tick();
        check("k2_pe", m_pe, 0);
        check("k2_x", m_x, 1);
        prev_pe = m_pe;
        for (int k = 3; k <= 1601; k++) begin
            tick();
            if (m_pe) m_pe_hi++;
            if (m_pe && prev_pe) m_pe_dbl++;
            prev_pe = m_pe;
            if (int'(m_x) > m_xmax) m_xmax = int'(m_x);
            if (m_ls) begin m_ls_n++; m_ls_k = k; m_ls_x = int'(m_x); end
            if (m_fs) m_fs_n++;
            if (!m_hs) begin m_hs_n++; if (m_hs_k0 < 0) begin m_hs_k0 = k; m_hs_x0 = int'(m_x); end end
            if (!m_bn && m_bn_x0 < 0) m_bn_x0 = int'(m_x);
            if (!a_pe) a_pe_lo++;
            if (a_ls) begin if (a_ls_k1 < 0) a_ls_k1 = k; else if (a_ls_k2 < 0) a_ls_k2 = k; end
            if (!a_hs && k < 800) a_hs_n++;
            if (s_fs) begin
                if (s_fs_n == 0) s_fs_k = k;
                else if (k - s_fs_last != 384) s_fs_gap++;
                s_fs_n++;
                s_fs_last = k;
            end
            if (!s_vs && k < 384) begin s_vs_n++; if (s_vs_y0 < 0) s_vs_y0 = int'(s_y); end
            if (s_bn !== (s_x < 10'd8 && s_y < 10'd6)) s_bn_bad++;
`ifdef VGA_FRAME_CNT_EN
            if (k == 1152) s_fc3 = int'(s_fc);
`endif
        end
        check("m_pe_hi", m_pe_hi, 800);
        check("m_pe_dbl", m_pe_dbl, 0);
        check("m_xmax", m_xmax, 799);
        check("m_ls_n", m_ls_n, 1);
        check("m_ls_k", m_ls_k, 1600);
        check("m_ls_x", m_ls_x, 0);
        check("m_fs_n", m_fs_n, 0);
        check("m_hs_n", m_hs_n, 192);
        check("m_hs_k0", m_hs_k0, 1312);
        check("m_hs_x0", m_hs_x0, 656);
        check("m_bn_x0", m_bn_x0, 640);
        check("a_pe_lo", a_pe_lo, 0);
        check("a_ls_k1", a_ls_k1, 800);
        check("a_ls_per", a_ls_k2 - a_ls_k1, 800);
        check("a_hs_n", a_hs_n, 96);
        check("s_fs_n", s_fs_n, 4);
        check("s_fs_k", s_fs_k, 384);
        check("s_fs_gap", s_fs_gap, 0);
        check("s_vs_n", s_vs_n, 64);
        check("s_vs_y0", s_vs_y0, 8);
        check("s_bn_bad", s_bn_bad, 0);
`ifdef VGA_FRAME_CNT_EN
        check("s_fc3", s_fc3, 3);
        check("m_fc0", m_fc, 0);
`endif
        wait_n = 0;
        while (!(s_x == 10'd5 && s_y == 10'd4) && wait_n < 1000) begin
            tick();
            wait_n++;
        end
        check("mid_wait", wait_n < 1000, 1);
        Reset_n = 1'b0;
        tick();
        check("mid_s", {s_x, s_y, s_ls, s_fs, s_pe}, 0);
        check("mid_m", {m_x, m_y, m_ls, m_fs, m_pe}, 0);
        check("mid_a", {a_x, a_y, a_ls, a_fs, a_pe}, 0);
`ifdef VGA_FRAME_CNT_EN
        check("mid_fc", s_fc, 0);
`endif
        Reset_n = 1'b1;
        tick();
        check("re_k0", {m_pe, m_ls, m_fs, a_ls, a_fs, s_ls, s_fs}, 0);
        tick();
        check("re_k1_pe", m_pe, 1);
        tick();
        check("re_k2_x", {m_x, s_x}, {10'd1, 10'd1});
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
